// File: rtl/conv_mac_pkg.sv
// rtl/conv_mac_pkg.sv - shared constants and state encoding for the convolution MAC sequencer
package conv_mac_pkg;

    localparam int ADDR_X_W_DEF = 5;
    localparam int ADDR_Y_W_DEF = 5;
    localparam int ADDR_Z_W_DEF = 6;
    localparam int MAX_SAMPLES  = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        MAC   = 3'd2,
        FLUSH = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/conv_idx_bounds.sv
// rtl/conv_idx_bounds.sv - per-output summation bounds lo/hi and last-output flag
module conv_idx_bounds #(
    parameter int SX_W = 6,
    parameter int SY_W = 6,
    parameter int IW   = 7
) (
    input  logic [IW-1:0]   k,
    input  logic [SX_W-1:0] sx,
    input  logic [SY_W-1:0] sy,
    output logic [IW-1:0]   lo,
    output logic [IW-1:0]   hi,
    output logic            last_k
);

    logic [IW-1:0] sx_e;
    logic [IW-1:0] sy_e;
    logic [IW-1:0] lo_d;
    logic [IW-1:0] sx_m1;

    // lo_d is k-(sy-1) read as two's complement; a set MSB means it went negative
    always_comb begin
        sx_e   = IW'(sx);
        sy_e   = IW'(sy);
        lo_d   = k - sy_e + IW'(1);
        sx_m1  = sx_e - IW'(1);
        lo     = lo_d[IW-1] ? '0 : lo_d;
        hi     = (k < sx_m1) ? k : sx_m1;
        last_k = (k == (sx_e + sy_e - IW'(2)));
    end

endmodule

// File: rtl/conv_mac_ctrl.sv
// rtl/conv_mac_ctrl.sv - 1-D convolution sequencer: addresses, accumulator control, Z writes
// Optional sticky completion interrupt under CONV_MAC_CTRL_IRQ_EN.
module conv_mac_ctrl
    import conv_mac_pkg::*;
#(
    parameter int ADDR_X_W = ADDR_X_W_DEF,
    parameter int ADDR_Y_W = ADDR_Y_W_DEF,
    parameter int ADDR_Z_W = ADDR_Z_W_DEF
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start_i,
    input  logic [ADDR_X_W:0]   size_x_i,
    input  logic [ADDR_Y_W:0]   size_y_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [ADDR_X_W-1:0] x_addr_o,
    output logic [ADDR_Y_W-1:0] y_addr_o,
    output logic                acc_clr_o,
    output logic                acc_en_o,
    output logic [ADDR_Z_W-1:0] z_addr_o,
    output logic                z_we_o
`ifdef CONV_MAC_CTRL_IRQ_EN
    ,
    input  logic                int_clr_i,
    output logic                int_o
`endif
);

    localparam int SX_W = ADDR_X_W + 1;
    localparam int SY_W = ADDR_Y_W + 1;
    localparam int IW   = ADDR_Z_W + 1;

    state_t state;
    state_t state_nx;

    logic [IW-1:0]       k;
    logic [IW-1:0]       i;
    logic [SX_W-1:0]     sx;
    logic [SY_W-1:0]     sy;
    logic [SX_W-1:0]     sx_in;
    logic [SY_W-1:0]     sy_in;
    logic [IW-1:0]       lo;
    logic [IW-1:0]       hi;
    logic                last_k;
    logic                issue;
    logic                issue_q;
    logic [IW-1:0]       y_diff;
    logic [ADDR_X_W-1:0] x_hold;
    logic [ADDR_Y_W-1:0] y_hold;

    always_comb begin
        sx_in = (size_x_i > SX_W'(MAX_SAMPLES)) ? SX_W'(MAX_SAMPLES) : size_x_i;
        sy_in = (size_y_i > SY_W'(MAX_SAMPLES)) ? SY_W'(MAX_SAMPLES) : size_y_i;
    end

    conv_idx_bounds #(
        .SX_W (SX_W),
        .SY_W (SY_W),
        .IW   (IW)
    ) u_bounds (
        .k      (k),
        .sx     (sx),
        .sy     (sy),
        .lo     (lo),
        .hi     (hi),
        .last_k (last_k)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nx = ((sx_in == '0) || (sy_in == '0)) ? DONE : CLR;
                end
            end
            CLR:     state_nx = MAC;
            MAC:     state_nx = (i == hi) ? FLUSH : MAC;
            FLUSH:   state_nx = WRITE;
            WRITE:   state_nx = last_k ? DONE : CLR;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign issue  = (state == MAC);
    assign y_diff = k - i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            k       <= '0;
            i       <= '0;
            sx      <= '0;
            sy      <= '0;
            issue_q <= 1'b0;
            x_hold  <= '0;
            y_hold  <= '0;
        end else begin
            issue_q <= issue;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        sx <= sx_in;
                        sy <= sy_in;
                        k  <= '0;
                        i  <= '0;
                    end
                end
                CLR: i <= lo;
                MAC: begin
                    x_hold <= i[ADDR_X_W-1:0];
                    y_hold <= y_diff[ADDR_Y_W-1:0];
                    if (i != hi) begin
                        i <= i + IW'(1);
                    end
                end
                WRITE: begin
                    if (!last_k) begin
                        k <= k + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Addresses follow the live indices while issuing and hold the last issued pair otherwise
    always_comb begin
        busy_o    = (state != IDLE);
        done_o    = (state == DONE);
        acc_clr_o = (state == CLR);
        z_we_o    = (state == WRITE);
        acc_en_o  = issue_q;
        z_addr_o  = k[ADDR_Z_W-1:0];
        x_addr_o  = issue ? i[ADDR_X_W-1:0] : x_hold;
        y_addr_o  = issue ? y_diff[ADDR_Y_W-1:0] : y_hold;
    end

`ifdef CONV_MAC_CTRL_IRQ_EN
    logic int_q;

    // A completion in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            int_q <= 1'b0;
        end else if (state == DONE) begin
            int_q <= 1'b1;
        end else if (int_clr_i) begin
            int_q <= 1'b0;
        end
    end

    assign int_o = int_q;
`endif

endmodule

// File: tb/tb_conv_mac_ctrl.sv
// tb/tb_conv_mac_ctrl.sv - self-checking bench for conv_mac_ctrl with datapath and convolution model
module tb_conv_mac_ctrl;

    localparam int AXW = 5;
    localparam int AYW = 5;
    localparam int AZW = 6;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           start_i = 1'b0;
    logic [AXW:0]   size_x_i = '0;
    logic [AYW:0]   size_y_i = '0;
    logic           busy_o;
    logic           done_o;
    logic [AXW-1:0] x_addr_o;
    logic [AYW-1:0] y_addr_o;
    logic           acc_clr_o;
    logic           acc_en_o;
    logic [AZW-1:0] z_addr_o;
    logic           z_we_o;
`ifdef CONV_MAC_CTRL_IRQ_EN
    logic           int_o;
    logic           int_clr_i = 1'b0;
`endif

    always #5 clk = ~clk;

    conv_mac_ctrl #(
        .ADDR_X_W (AXW),
        .ADDR_Y_W (AYW),
        .ADDR_Z_W (AZW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start_i   (start_i),
        .size_x_i  (size_x_i),
        .size_y_i  (size_y_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .x_addr_o  (x_addr_o),
        .y_addr_o  (y_addr_o),
        .acc_clr_o (acc_clr_o),
        .acc_en_o  (acc_en_o),
        .z_addr_o  (z_addr_o),
        .z_we_o    (z_we_o)
`ifdef CONV_MAC_CTRL_IRQ_EN
        ,
        .int_clr_i (int_clr_i),
        .int_o     (int_o)
`endif
    );

    typedef struct {
        int sx;
        int sy;
        int mode;
        int exp_writes;
        int exp_done;
        int chk_k;
        int chk_z;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   xmem [32];
    int   ymem [32];
    int   last_z [64];
    vec_t tbl [8];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int clampi(input int n);
        return (n > 32) ? 32 : n;
    endfunction

    function automatic int n_terms(input int sx, input int sy, input int k);
        int c = 0;
        for (int j = 0; j < sx; j++)
            if (k - j >= 0 && k - j < sy) c++;
        return c;
    endfunction

    function automatic int ref_z(input int sx, input int sy, input int k);
        int s = 0;
        for (int j = 0; j < sx; j++)
            if (k - j >= 0 && k - j < sy) s += xmem[j] * ymem[k - j];
        return s & 16'hFFFF;
    endfunction

    function automatic int ref_done(input int sx, input int sy);
        int c = 1;
        if (sx == 0 || sy == 0) return 1;
        for (int k = 0; k <= sx + sy - 2; k++) c += n_terms(sx, sy, k) + 3;
        return c;
    endfunction

    task automatic fill_mem(input int mode);
        for (int j = 0; j < 32; j++) begin
            xmem[j] = (mode == 2) ? 255 : int'($urandom_range(0, 255));
            ymem[j] = (mode == 2) ? 255 : int'($urandom_range(0, 255));
        end
        if (mode == 1) begin
            xmem[0] = 1; xmem[1] = 2;
            ymem[0] = 3; ymem[1] = 4;
        end
    endtask

    // Cycle 1 is the first cycle after the edge that accepts start; models memories and S_Z
    task automatic run_conv(input string tag, input int sx_in, input int sy_in,
                            input int exp_writes, input int exp_done, input int glitch_cyc);
        int sx = clampi(sx_in);
        int sy = clampi(sy_in);
        int wr_n = 0, en_cnt = 0, done_cyc = -1, overlap = 0, strobes = 0;
        int s_acc = 0, xd = 0, yd = 0;
        int wr_addr [64];
        int wr_en [64];
        @(negedge clk);
        check({tag, "_idle_before"}, busy_o, 0);
        size_x_i = 6'(sx_in);
        size_y_i = 6'(sy_in);
        start_i  = 1'b1;
        @(negedge clk);
        start_i  = 1'b0;
        size_x_i = 6'($urandom);
        size_y_i = 6'($urandom);
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            if (cyc == 1) check({tag, "_busy_rise"}, busy_o, 1);
            if (acc_clr_o && acc_en_o) overlap++;
            if (acc_clr_o || acc_en_o || z_we_o) strobes++;
            if (acc_en_o) en_cnt++;
            if (z_we_o) begin
                if (wr_n < 64) begin
                    wr_addr[wr_n] = int'(z_addr_o);
                    last_z[wr_n]  = s_acc;
                    wr_en[wr_n]   = en_cnt;
                end
                wr_n++;
                en_cnt = 0;
            end
            if (acc_clr_o) s_acc = 0;
            else if (acc_en_o) s_acc = (s_acc + xd * yd) & 16'hFFFF;
            xd = xmem[x_addr_o];
            yd = ymem[y_addr_o];
            start_i = (cyc == glitch_cyc);
            if (done_o) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        start_i = 1'b0;
        if (done_cyc < 0) check({tag, "_timeout"}, 0, 1);
        @(negedge clk);
        check({tag, "_done_cycle"}, done_cyc, exp_done);
        check({tag, "_done_pulse"}, done_o, 0);
        check({tag, "_idle_after"}, busy_o, 0);
        check({tag, "_writes"}, wr_n, exp_writes);
        check({tag, "_clr_en_overlap"}, overlap, 0);
        if (exp_writes == 0) check({tag, "_no_strobes"}, strobes, 0);
        for (int j = 0; j < wr_n && j < 64; j++) begin
            check($sformatf("%s_zaddr%0d", tag, j), wr_addr[j], j);
            check($sformatf("%s_zdata%0d", tag, j), last_z[j], ref_z(sx, sy, j));
            check($sformatf("%s_en_cnt%0d", tag, j), wr_en[j], n_terms(sx, sy, j));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2, 2, 1, 3, 14, 1, 10};
        tbl[1] = '{1, 1, 2, 1, 5, 0, 'hFE01};
        tbl[2] = '{0, 5, 0, 0, 1, -1, 0};
        tbl[3] = '{5, 0, 0, 0, 1, -1, 0};
        tbl[4] = '{3, 4, 0, 6, 31, -1, 0};
        tbl[5] = '{40, 1, 0, 32, 129, -1, 0};
        tbl[6] = '{1, 4, 0, 4, 17, -1, 0};
        tbl[7] = '{32, 32, 2, 63, 1214, 31, 'hC020};

        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_xaddr", x_addr_o, 0);
        check("rst_yaddr", y_addr_o, 0);
        check("rst_strobes", {acc_clr_o, acc_en_o, z_we_o}, 0);
        check("rst_zaddr", z_addr_o, 0);
        rstn = 1'b1;

        for (int v = 0; v < 8; v++) begin
            fill_mem(tbl[v].mode);
            run_conv($sformatf("tbl%0d", v), tbl[v].sx, tbl[v].sy,
                     tbl[v].exp_writes, tbl[v].exp_done, 0);
            if (tbl[v].chk_k >= 0)
                check($sformatf("tbl%0d_zconst", v), last_z[tbl[v].chk_k], tbl[v].chk_z);
        end

        // start pulsed in a MAC cycle (k=1) must not disturb the run
        fill_mem(0);
        run_conv("glitch", 3, 3, 5, ref_done(3, 3), 6);

        for (int r = 0; r < 6; r++) begin
            int sx = int'($urandom_range(0, 36));
            int sy = int'($urandom_range(0, 36));
            int sxc = clampi(sx);
            int syc = clampi(sy);
            fill_mem(0);
            run_conv($sformatf("rnd%0d", r), sx, sy,
                     (sxc == 0 || syc == 0) ? 0 : sxc + syc - 1, ref_done(sxc, syc), 0);
        end

        // reset in the second MAC cycle of k=1 of a 4x4 run
        fill_mem(0);
        @(negedge clk);
        size_x_i = 6'd4;
        size_y_i = 6'd4;
        start_i  = 1'b1;
        @(negedge clk);
        start_i  = 1'b0;
        repeat (6) @(negedge clk);
        check("midrst_busy_before", busy_o, 1);
        check("midrst_en_before", acc_en_o, 1);
        check("midrst_xaddr_before", x_addr_o, 1);
        rstn = 1'b0;
        #1;
        check("midrst_busy", busy_o, 0);
        check("midrst_en", acc_en_o, 0);
        check("midrst_xaddr", x_addr_o, 0);
        check("midrst_yaddr", y_addr_o, 0);
        check("midrst_strobes", {acc_clr_o, z_we_o, done_o}, 0);
        repeat (2) begin
            @(negedge clk);
            check("midrst_no_write", z_we_o, 0);
        end
        rstn = 1'b1;
        fill_mem(1);
        run_conv("after_rst", 2, 2, 3, 14, 0);

`ifdef CONV_MAC_CTRL_IRQ_EN
        check("int_after_reset_run", int_o, 1);
        repeat (3) @(negedge clk);
        check("int_sticky", int_o, 1);
        int_clr_i = 1'b1;
        @(negedge clk);
        int_clr_i = 1'b0;
        check("int_cleared", int_o, 0);
        int_clr_i = 1'b1;
        fill_mem(2);
        run_conv("irq_sim", 1, 1, 1, 5, 0);
        check("int_set_wins", int_o, 1);
        @(negedge clk);
        check("int_clr_next", int_o, 0);
        int_clr_i = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
